cmp_wide_seq: RTL and testbench

Word-serial wide comparator controller. It compares two WORDS×LEN-bit operands by stepping one shared LEN-bit magnitude/equality comparator from the most significant word down, and stops at the first unequal word. The block sits in front of the combinational comparator datapath and handles mode selection (signed/unsigned), operand capture, iteration, early termination and the result handshake. Use it where a full-width parallel compare is too large.

---
 rtl/cmp_wide_seq_if.sv | 27 ++
 rtl/cmp_wide_seq.sv | 110 +++++++++++
 tb/tb_cmp_wide_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cmp_wide_seq_if.sv
// Request/result handshake bundle for the word-serial wide comparator.
interface cmp_wide_seq_if #(
  parameter int LEN   = 16,
  parameter int WORDS = 4
);
  localparam int W = LEN * WORDS;

  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic         eq;
  logic         gt;
  logic         lt;

  modport master (
    output start, is_signed, a, b,
    input  ready, done, eq, gt, lt
  );

  modport slave (
    input  start, is_signed, a, b,
    output ready, done, eq, gt, lt
  );
endinterface

// File: rtl/cmp_wide_seq.sv
// Word-serial wide comparator: one LEN-bit comparator stepped from the top word
// down, stopping at the first unequal word. Only the top word honours signed mode.
module cmp_wide_seq #(
  parameter int LEN   = 16,
  parameter int WORDS = 4
) (
  input logic           clk,
  input logic           rst,
  cmp_wide_seq_if.slave bus
);
  localparam int W  = LEN * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] TOP = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, CMP, FIN} state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            sgn_q;
  logic [IW-1:0]   idx;
  logic            done_q;
  logic            eq_q;
  logic            gt_q;
  logic            lt_q;

  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [LEN-1:0]  wa;
  logic [LEN-1:0]  wb;
  logic            w_eq;
  logic            w_gt;
  logic            w_lt;

  // Shared word comparator; signed only when looking at the top word.
  always_comb begin
    a_sh = a_q >> (int'(idx) * LEN);
    b_sh = b_q >> (int'(idx) * LEN);
    wa   = a_sh[LEN-1:0];
    wb   = b_sh[LEN-1:0];
    w_eq = (wa == wb);
    w_gt = 1'b0;
    w_lt = 1'b0;
    if (idx == TOP && sgn_q) begin
      w_gt = ($signed(wa) > $signed(wb));
      w_lt = ($signed(wa) < $signed(wb));
    end else begin
      w_gt = (wa > wb);
      w_lt = (wa < wb);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      idx    <= TOP;
      done_q <= 1'b0;
      eq_q   <= 1'b0;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            sgn_q <= bus.is_signed;
            idx   <= TOP;
            state <= CMP;
          end
        end
        CMP: begin
          if (!w_eq) begin
            eq_q   <= 1'b0;
            gt_q   <= w_gt;
            lt_q   <= w_lt;
            done_q <= 1'b1;
            state  <= FIN;
          end else if (idx == '0) begin
            eq_q   <= 1'b1;
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            done_q <= 1'b1;
            state  <= FIN;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        FIN: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.done  = done_q;
  assign bus.eq    = eq_q;
  assign bus.gt    = gt_q;
  assign bus.lt    = lt_q;
endmodule

// File: tb/tb_cmp_wide_seq.sv
// Directed bench for cmp_wide_seq with LEN=16, WORDS=4; cycles counted from the accept edge.
module tb_cmp_wide_seq;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  cmp_wide_seq_if #(.LEN(16), .WORDS(4)) bus ();

  cmp_wide_seq #(.LEN(16), .WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  // Waits for READY in IDLE, then presents one START for exactly one edge.
  task automatic accept(input logic [63:0] av, input logic [63:0] bv, input logic s);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) check("accept_ready", 64'(bus.ready), 64'd1);
    bus.a         = av;
    bus.b         = bv;
    bus.is_signed = s;
    bus.start     = 1'b1;
    @(posedge clk);
    #1 bus.start  = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 99;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [63:0] av, input logic [63:0] bv,
                     input logic s, input int exp_cyc, input logic e, input logic g, input logic l);
    int c;
    accept(av, bv, s);
    wait_done(c);
    check({tag, "_done_cyc"}, 64'(c), 64'(exp_cyc));
    check({tag, "_eq"}, 64'(bus.eq), 64'(e));
    check({tag, "_gt"}, 64'(bus.gt), 64'(g));
    check({tag, "_lt"}, 64'(bus.lt), 64'(l));
    @(negedge clk);
    check({tag, "_ready_after"}, 64'(bus.ready), 64'd1);
    check({tag, "_done_single"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int pulses;
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    #12;
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_results", {61'd0, bus.eq, bus.gt, bus.lt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run("equal", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 5, 1'b1, 1'b0, 1'b0);
    run("top_uns", 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    run("top_sgn", 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 2, 1'b0, 1'b0, 1'b1);
    run("low_uns", 64'hFFFF_FFFF_FFFF_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5, 1'b0, 1'b0, 1'b1);

    // Busy protection: START with fresh operands while CMP runs must be ignored.
    accept(64'h0000_0000_0001_0000, 64'h0000_0000_0000_FFFF, 1'b0);
    bus.start = 1'b1;
    bus.a     = 64'd0;
    bus.b     = 64'd1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("busy_done_c%0d", c), 64'(bus.done), 64'(c == 4));
      check($sformatf("busy_ready_c%0d", c), 64'(bus.ready), 64'(c >= 5));
      if (c == 4) begin
        check("busy_gt", 64'(bus.gt), 64'd1);
        check("busy_eq", 64'(bus.eq), 64'd0);
      end
      if (c == 3) begin
        @(posedge clk);
        #1 bus.start = 1'b0;
      end
    end

    // Asynchronous reset in cycle 2 of an equal compare.
    accept(64'hAAAA_5555_1234_0000, 64'hAAAA_5555_1234_0000, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_ready", 64'(bus.ready), 64'd1);
    check("arst_results", {61'd0, bus.eq, bus.gt, bus.lt}, 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("arst_no_done", 64'(pulses), 64'd0);
    run("post_rst", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 5, 1'b1, 1'b0, 1'b0);

    // Back-to-back: first compare decided on the top word, second is equal.
    accept(64'h0002_0000_0000_0000, 64'h0001_FFFF_FFFF_FFFF, 1'b0);
    bus.start = 1'b1;
    bus.a     = 64'h5A5A_0000_FFFF_1111;
    bus.b     = 64'h5A5A_0000_FFFF_1111;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("b2b_done_c%0d", c), 64'(bus.done), 64'(c == 2 || c == 8));
      check($sformatf("b2b_ready_c%0d", c), 64'(bus.ready), 64'(c == 3));
      check($sformatf("b2b_gt_c%0d", c), 64'(bus.gt), 64'(c >= 2 && c < 8));
      check($sformatf("b2b_eq_c%0d", c), 64'(bus.eq), 64'(c == 1 || c == 8));
      check($sformatf("b2b_lt_c%0d", c), 64'(bus.lt), 64'd0);
      if (c == 3) begin
        @(posedge clk);
        #1 bus.start = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_ready_end", 64'(bus.ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
